// File: rtl/stickyx_nch_if.sv
// Processor register bus for the sticky alarm block.
// Master drives select/strobe/address/data, slave returns read data.
interface stickyx_nch_if #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 6
);
    logic             upen;
    logic             upws;
    logic [ADDRW-1:0] upa;
    logic [WIDTH-1:0] updi;
    logic [WIDTH-1:0] updo;

    modport master (
        output upen, upws, upa, updi,
        input  updo
    );

    modport slave (
        input  upen, upws, upa, updi,
        output updo
    );
endinterface

// File: rtl/stickyx_nch.sv
// Multi-channel sticky alarm latch with W1C clear, interrupt enables,
// per-channel and combined registered interrupts and a force mode.
module stickyx_nch #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int ADDRW = 6,
    parameter int EDGE  = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 upactive,
    input  logic [NCH*WIDTH-1:0] alarm,
    stickyx_nch_if.slave         bus,
    output logic [NCH*WIDTH-1:0] lalarm,
    output logic [NCH-1:0]       irq_ch,
    output logic                 irq
);
    localparam int CHW = ADDRW - 2;

    logic [NCH-1:0][WIDTH-1:0] sticky;
    logic [NCH-1:0][WIDTH-1:0] sticky_nx;
    logic [NCH-1:0][WIDTH-1:0] ien;
    logic [NCH-1:0][WIDTH-1:0] ien_nx;
    logic [NCH*WIDTH-1:0]      alarm_q;
    logic [NCH*WIDTH-1:0]      set;
    logic [NCH-1:0]            irq_nx;
    logic [NCH-1:0]            ch_hit;
    logic [CHW-1:0]            ch;
    logic [1:0]                sel;
    logic                      wr;

    assign ch  = bus.upa[ADDRW-1:2];
    assign sel = bus.upa[1:0];
    assign wr  = bus.upen & bus.upws;

    // Rising-edge mode only sets on a 0->1 transition of the raw alarm
    assign set = (EDGE != 0) ? (alarm & ~alarm_q) : alarm;

    assign lalarm = sticky;

    // One-hot channel decode; out-of-range channels match nothing
    always_comb begin
        ch_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_hit[c] = (int'(ch) == c);
        end
    end

    // Next sticky/ien state and per-channel interrupt terms
    always_comb begin
        sticky_nx = sticky;
        ien_nx    = ien;
        irq_nx    = '0;
        for (int c = 0; c < NCH; c++) begin
            if (upactive) begin
                if (wr && ch_hit[c] && sel == 2'd0) begin
                    sticky_nx[c] = set[c*WIDTH +: WIDTH]
                                 | (sticky[c] & ~bus.updi);
                end else begin
                    sticky_nx[c] = set[c*WIDTH +: WIDTH] | sticky[c];
                end
            end else if (wr && ch_hit[c] && sel == 2'd0) begin
                sticky_nx[c] = bus.updi;
            end
            if (wr && ch_hit[c] && sel == 2'd1) begin
                ien_nx[c] = bus.updi;
            end
            irq_nx[c] = |(sticky[c] & ien[c]);
        end
    end

    // Combinational read mux, zero when not selected
    always_comb begin
        bus.updo = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.upen && ch_hit[c]) begin
                case (sel)
                    2'd0:    bus.updo = sticky[c];
                    2'd1:    bus.updo = ien[c];
                    2'd2:    bus.updo = alarm[c*WIDTH +: WIDTH];
                    default: bus.updo = '0;
                endcase
            end
        end
    end

    // State registers; irq follows irq_ch on the same edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky  <= '0;
            ien     <= '0;
            alarm_q <= '0;
            irq_ch  <= '0;
            irq     <= 1'b0;
        end else begin
            sticky  <= sticky_nx;
            ien     <= ien_nx;
            alarm_q <= alarm;
            irq_ch  <= irq_nx;
            irq     <= |irq_nx;
        end
    end
endmodule

// File: tb/tb_stickyx_nch.sv
// Bench for stickyx_nch: level and edge instances driven in lockstep,
// checked by vector table, directed sequences and a random model run.
module tb_stickyx_nch;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ua;
    logic [N*W-1:0] al;
    logic          en;
    logic          ws;
    logic [AW-1:0] addr;
    logic [W-1:0]  di;

    logic [N*W-1:0] lal0, lal1;
    logic [N-1:0]   irqch0, irqch1;
    logic           irq0, irq1;

    int total = 0;
    int bad   = 0;

    stickyx_nch_if #(.WIDTH(W), .ADDRW(AW)) b0 ();
    stickyx_nch_if #(.WIDTH(W), .ADDRW(AW)) b1 ();

    assign b0.upen = en;
    assign b0.upws = ws;
    assign b0.upa  = addr;
    assign b0.updi = di;
    assign b1.upen = en;
    assign b1.upws = ws;
    assign b1.upa  = addr;
    assign b1.updi = di;

    stickyx_nch #(.WIDTH(W), .NCH(N), .ADDRW(AW), .EDGE(0)) dut0 (
        .clk(clk), .rstn(rstn), .upactive(ua), .alarm(al), .bus(b0),
        .lalarm(lal0), .irq_ch(irqch0), .irq(irq0)
    );

    stickyx_nch #(.WIDTH(W), .NCH(N), .ADDRW(AW), .EDGE(1)) dut1 (
        .clk(clk), .rstn(rstn), .upactive(ua), .alarm(al), .bus(b1),
        .lalarm(lal1), .irq_ch(irqch1), .irq(irq1)
    );

    always #5 clk = ~clk;

    // reference model, index e = EDGE setting
    logic [W-1:0] m_st  [2][N];
    logic [W-1:0] m_ien [2][N];
    logic [W-1:0] m_aq  [2][N];
    logic [N-1:0] m_irqch [2];
    logic         m_irq   [2];

    typedef struct {
        bit          ua;
        logic [31:0] al;
        bit          en;
        bit          ws;
        logic [5:0]  a;
        logic [7:0]  di;
        logic [31:0] exp_lal;
        bit          exp_irq;
    } vec_t;

    vec_t vt[14];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            for (int c = 0; c < N; c++) begin
                m_st[e][c]  = '0;
                m_ien[e][c] = '0;
                m_aq[e][c]  = '0;
            end
            m_irqch[e] = '0;
            m_irq[e]   = 1'b0;
        end
    endtask

    task automatic model_clk();
        logic [W-1:0] a, s;
        logic [N-1:0] nirq;
        int ch, sel;
        bit wr;
        if (!rstn) begin
            model_reset();
            return;
        end
        ch  = int'(addr) / 4;
        sel = int'(addr) % 4;
        wr  = en && ws;
        for (int e = 0; e < 2; e++) begin
            for (int c = 0; c < N; c++)
                nirq[c] = |(m_st[e][c] & m_ien[e][c]);
            for (int c = 0; c < N; c++) begin
                a = al[c*W +: W];
                s = (e == 1) ? (a & ~m_aq[e][c]) : a;
                if (ua) begin
                    if (wr && ch == c && sel == 0)
                        m_st[e][c] = s | (m_st[e][c] & ~di);
                    else
                        m_st[e][c] = s | m_st[e][c];
                end else if (wr && ch == c && sel == 0) begin
                    m_st[e][c] = di;
                end
                if (wr && ch == c && sel == 1)
                    m_ien[e][c] = di;
                m_aq[e][c] = a;
            end
            m_irqch[e] = nirq;
            m_irq[e]   = |nirq;
        end
    endtask

    function automatic logic [W-1:0] m_read(int e);
        int ch, sel;
        ch  = int'(addr) / 4;
        sel = int'(addr) % 4;
        if (!en || ch >= N) return '0;
        case (sel)
            0: return m_st[e][ch];
            1: return m_ien[e][ch];
            2: return al[ch*W +: W];
            default: return '0;
        endcase
    endfunction

    function automatic logic [N*W-1:0] m_lal(int e);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = m_st[e][c];
        return v;
    endfunction

    task automatic check_all();
        chk("lalarm_e0", lal0, m_lal(0));
        chk("lalarm_e1", lal1, m_lal(1));
        chk("irq_ch_e0", 32'(irqch0), 32'(m_irqch[0]));
        chk("irq_ch_e1", 32'(irqch1), 32'(m_irqch[1]));
        chk("irq_e0", 32'(irq0), 32'(m_irq[0]));
        chk("irq_e1", 32'(irq1), 32'(m_irq[1]));
        chk("updo_e0", 32'(b0.updo), 32'(m_read(0)));
        chk("updo_e1", 32'(b1.updo), 32'(m_read(1)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clk();
        #1;
        check_all();
    endtask

    task automatic idle();
        en = 0; ws = 0; addr = '0; di = '0;
    endtask

    task automatic do_reset(logic [N*W-1:0] hold_al);
        al = hold_al;
        rstn = 1'b0;
        tick();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; ua = 1'b1; al = '0;
        idle();
        model_reset();

        vt[0]  = '{1, 32'h0000_0500, 0, 0, 6'd0,  8'h00, 32'h0000_0500, 0};
        vt[1]  = '{1, 32'h0000_0000, 0, 0, 6'd0,  8'h00, 32'h0000_0500, 0};
        vt[2]  = '{1, 32'h0000_0000, 1, 1, 6'd4,  8'h01, 32'h0000_0400, 0};
        vt[3]  = '{1, 32'h0000_0008, 1, 1, 6'd0,  8'h08, 32'h0000_0408, 0};
        vt[4]  = '{1, 32'h0000_0000, 1, 1, 6'd0,  8'h08, 32'h0000_0400, 0};
        vt[5]  = '{1, 32'h0000_0000, 1, 1, 6'd13, 8'h80, 32'h0000_0400, 0};
        vt[6]  = '{1, 32'h8000_0000, 0, 0, 6'd0,  8'h00, 32'h8000_0400, 0};
        vt[7]  = '{1, 32'h0000_0000, 0, 0, 6'd0,  8'h00, 32'h8000_0400, 1};
        vt[8]  = '{1, 32'h0000_0000, 1, 1, 6'd12, 8'h80, 32'h0000_0400, 1};
        vt[9]  = '{1, 32'h0000_0000, 0, 0, 6'd0,  8'h00, 32'h0000_0400, 0};
        vt[10] = '{0, 32'hFFFF_FFFF, 1, 1, 6'd0,  8'hA5, 32'h0000_04A5, 0};
        vt[11] = '{0, 32'hFFFF_FFFF, 1, 1, 6'd20, 8'hFF, 32'h0000_04A5, 0};
        vt[12] = '{0, 32'hFFFF_FFFF, 1, 0, 6'd20, 8'h00, 32'h0000_04A5, 0};
        vt[13] = '{1, 32'h0000_0000, 0, 0, 6'd0,  8'h00, 32'h0000_04A5, 0};

        // reset state
        tick();
        #1;
        chk("rst_lalarm", lal0 | lal1, 32'h0);
        chk("rst_irq", 32'({irq0, irq1, irqch0, irqch1}), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // level-mode vector table
        for (int i = 0; i < 14; i++) begin
            ua = vt[i].ua; al = vt[i].al;
            en = vt[i].en; ws = vt[i].ws;
            addr = vt[i].a; di = vt[i].di;
            tick();
            chk($sformatf("vec%0d_lalarm", i), lal0, vt[i].exp_lal);
            chk($sformatf("vec%0d_irq", i), 32'(irq0), 32'(vt[i].exp_irq));
        end

        // force-mode reads: out of range and loaded value
        ua = 0; al = '1; en = 1; ws = 0; addr = 6'd20;
        #1 chk("oor_read", 32'(b0.updo), 32'h0);
        addr = 6'd0;
        #1 chk("force_read", 32'(b0.updo), 32'hA5);
        addr = 6'd2;
        #1 chk("raw_read", 32'(b0.updo), 32'hFF);
        addr = 6'd3;
        #1 chk("rsvd_read", 32'(b0.updo), 32'h0);
        ua = 1; idle();

        // edge mode: held alarm, cleared once, no re-set until 0->1
        do_reset('0);
        ua = 1;
        al = 32'h0001_0000;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                en = 1; ws = 1; addr = 6'd8; di = 8'h01;
            end else begin
                idle();
            end
            tick();
            chk($sformatf("edge_hold%0d", i), 32'(lal1[16]),
                (i < 3) ? 32'h1 : 32'h0);
        end
        idle();
        al = '0;
        tick();
        chk("edge_low", 32'(lal1[16]), 32'h0);
        al = 32'h0001_0000;
        tick();
        chk("edge_rise", 32'(lal1[16]), 32'h1);

        // edge mode with alarm high across reset release
        do_reset('1);
        tick();
        chk("edge_rst_rel", lal1, 32'hFFFF_FFFF);

        // interrupt then asynchronous reset between edges
        al = '0;
        en = 1; ws = 1; addr = 6'd1; di = 8'hFF;
        tick();
        idle();
        al = 32'h0000_0001;
        tick();
        tick();
        chk("pre_rst_irq", 32'({irq0, irqch0[0]}), 32'h3);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("async_lalarm", lal0 | lal1, 32'h0);
        chk("async_irq", 32'({irq0, irq1, irqch0, irqch1}), 32'h0);
        check_all();

        // write in progress while reset held is lost
        ua = 0; en = 1; ws = 1; addr = 6'd0; di = 8'hFF;
        tick();
        idle();
        @(negedge clk);
        rstn = 1'b1;
        al = '0;
        tick();
        chk("rst_mid_write", lal0 | lal1, 32'h0);

        // random run against the model
        for (int i = 0; i < 3000; i++) begin
            ua   = ($urandom_range(0, 7) != 0);
            al   = $urandom & $urandom;
            en   = $urandom_range(0, 1) == 1;
            ws   = $urandom_range(0, 1) == 1;
            addr = AW'($urandom);
            di   = W'($urandom);
            rstn = ($urandom_range(0, 299) != 0);
            tick();
        end
        rstn = 1'b1;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
